// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and shared-bus arbiter.
// A CPU write to the DMA register starts a copy of DMA_LEN bytes from
// {src_hi,8'h00} to FE00. Each byte takes BYTE_CYCLES clocks: read, latch,
// write, idle. While the copy runs, the CPU may use the bus only for HRAM,
// and only in the phases where the DMA is not driving it.
module oam_dma_arbiter #(
   parameter int unsigned DMA_LEN      = 160,
   parameter int unsigned BYTE_CYCLES  = 4,
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] HRAM_LO      = 16'hFF80,
   parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_wait,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active
);

   localparam int unsigned   IW       = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
   localparam logic [1:0]    PH_LAST  = 2'(BYTE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DMA_LEN - 1);
   localparam logic [15:0]   OAM_BASE = 16'hFE00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFER  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    src_hi_q, src_hi_d;
   logic [7:0]    data_q, data_d;

   // CPU address decode shared by the next-state and output logic.
   logic reg_hit, reg_wr, reg_rd, hram_hit;
   assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
   assign reg_wr   = cpu_write && reg_hit;
   assign reg_rd   = cpu_read && reg_hit;
   assign hram_hit = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);

   // State register: all sequential state, cleared asynchronously.
   // NOTE: non-blocking assignments here so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         phase_q  <= 2'd0;
         idx_q    <= '0;
         src_hi_q <= 8'hFF;
         data_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         idx_q    <= idx_d;
         src_hi_q <= src_hi_d;
         data_q   <= data_d;
      end
   end

   // Next state: START delay count, per-byte phase/index walk, register restart.
   always_comb begin
      // NOTE: every target gets a hold default first, so no path infers a latch.
      state_d  = state_q;
      phase_d  = phase_q;
      idx_d    = idx_q;
      src_hi_d = src_hi_q;
      data_d   = data_q;

      case (state_q)
         ST_IDLE: ;
         ST_START: begin
            if (phase_q == PH_LAST) begin
               state_d = ST_XFER;
               phase_d = 2'd0;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         ST_XFER: begin
            // Byte read in phase 0 is valid on the bus one cycle later.
            if (phase_q == 2'd1) begin
               data_d = mem_rdata;
            end
            if (phase_q == PH_LAST) begin
               phase_d = 2'd0;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A register write restarts from any state and discards the byte in flight.
      if (reg_wr) begin
         src_hi_d = cpu_wdata;
         state_d  = ST_START;
         phase_d  = 2'd0;
         idx_d    = '0;
      end
   end

   // Outputs: CPU routing, DMA bus cycles, and forced-quiet bus during reset.
   logic xfer, bus_busy;
   assign xfer     = (state_q == ST_XFER);
   assign bus_busy = xfer && ((phase_q == 2'd0) || (phase_q == 2'd2));

   always_comb begin
      cpu_rdata  = 8'h00;
      cpu_wait   = 1'b0;
      mem_addr   = 16'h0000;
      mem_wdata  = 8'h00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      dma_active = (state_q != ST_IDLE);

      if (reset) begin
         if (reg_hit && (cpu_read || cpu_write)) begin
            // Register access is local and never reaches the shared bus.
            cpu_rdata = reg_rd ? src_hi_q : 8'h00;
         end else if (!xfer || (hram_hit && !bus_busy)) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = cpu_read;
            mem_write = cpu_write;
            cpu_rdata = mem_rdata;
         end else if (hram_hit) begin
            cpu_wait = cpu_read || cpu_write;
         end else begin
            // Non-HRAM traffic during a copy: reads see open bus, writes vanish.
            cpu_rdata = 8'hFF;
         end

         // The CPU never owns the bus in phases 0/2, so these cannot collide.
         if (xfer && !reg_wr) begin
            if (phase_q == 2'd0) begin
               mem_addr = {src_hi_q, 8'h00} + 16'(idx_q);
               mem_read = 1'b1;
            end else if (phase_q == 2'd2) begin
               mem_addr  = OAM_BASE + 16'(idx_q);
               mem_wdata = data_q;
               mem_write = 1'b1;
            end
         end
      end else begin
         dma_active = 1'b0;
      end
   end

endmodule
